// File: rtl/romload_pkg.sv
// Shared definitions for the ROM stream loader: load-mode codes, FSM states,
// the FIFO word layout and the GBA header offsets used by the optional
// checksum (ROMLOAD_CHECKSUM_EN).
package romload_pkg;

    localparam logic [2:0] LOAD_IDLE = 3'd0;
    localparam logic [2:0] LOAD_ROM  = 3'd1;
    localparam logic [2:0] LOAD_CRAM = 3'd2;
    localparam logic [2:0] LOAD_CFG  = 3'd3;
    localparam logic [2:0] LOAD_BIOS = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // One SDRAM word as it travels through the FIFO (address carried alongside)
    typedef struct packed {
        logic [1:0]  ds;
        logic [15:0] data;
    } word_t;

    // GBA header: checksum covers 0xA0..0xBC, complement byte sits at 0xBD
    localparam int HDR_SUM_FIRST = 'hA0;
    localparam int HDR_CHK       = 'hBD;

    function automatic logic mode_valid(input logic [2:0] m);
        return (m == LOAD_ROM) || (m == LOAD_CRAM) || (m == LOAD_CFG) || (m == LOAD_BIOS);
    endfunction

endpackage

// File: rtl/rom_stream_loader_if.sv
// SDRAM write port of the ROM stream loader: request held until a one-cycle ack.
interface rom_stream_loader_if #(
    parameter int AW = 25
) ();
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [1:0]    mem_ds;
    logic          mem_ack;

    modport master (output mem_req, mem_addr, mem_wdata, mem_ds, input mem_ack);
    modport slave  (input mem_req, mem_addr, mem_wdata, mem_ds, output mem_ack);
endinterface

// File: rtl/romload_fifo.sv
// Synchronous word FIFO with full/empty flags. A pop and a push in the same
// cycle are both honoured even when full: the pop frees the slot first.
module romload_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    output logic         push_ok_o,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_q, rd_q;
    logic         do_push, do_pop;

    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign push_ok_o = do_push;
    assign dout_o    = mem_q[rd_q[PW-1:0]];

    // Read/write pointers with an extra wrap bit to tell full from empty
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage needs no reset; the pointers say what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[PW-1:0]] <= din_i;
    end

endmodule

// File: rtl/rom_stream_loader.sv
// Core-side sink for the IOSys ROM byte stream: packs bytes into 16-bit LE
// words, queues them and writes them to SDRAM at the base of the load mode.
// Optional feature macro: ROMLOAD_CHECKSUM_EN (GBA header checksum on mode 1).
module rom_stream_loader
    import romload_pkg::*;
#(
    parameter int            AW        = 25,
    parameter logic [AW-1:0] ROM_BASE  = 25'h000_0000,
    parameter logic [AW-1:0] CRAM_BASE = 25'h1F0_0000,
    parameter logic [AW-1:0] BIOS_BASE = 25'h1FC_0000,
    parameter int            DEPTH     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          rom_loading,
    input  logic [7:0]          rom_do,
    input  logic                rom_do_valid,
    rom_stream_loader_if.master mem,
    output logic                busy,
    output logic                load_done,
    output logic [2:0]          load_mode,
    output logic [AW:0]         load_bytes,
    output logic                overflow,
    output logic [31:0]         cfg_word,
    output logic                header_ok
);
    localparam int FW = AW + $bits(word_t);

    state_t        state_q, state_d;
    logic [2:0]    mode_q;
    logic          hold_q;      // last completed mode still on rom_loading
    logic [AW:0]   bytes_q;
    logic          phase_q;     // an even byte is waiting in pair_q
    logic [7:0]    pair_q;
    logic [AW-1:0] ptr_q;
    logic          ovf_q;
    logic [31:0]   cfg_q;

    logic          req_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   wdata_q;
    logic [1:0]    ds_q;

    logic          mode_ok, idle_go, done_go, start, leave, take, drained;
    logic          push, push_ok, pop, fifo_full, fifo_empty;
    word_t         push_word, head_word;
    logic [FW-1:0] fifo_din, fifo_dout;

    function automatic logic [AW-1:0] base_of(input logic [2:0] m);
        case (m)
            LOAD_CRAM: return CRAM_BASE;
            LOAD_BIOS: return BIOS_BASE;
            default:   return ROM_BASE;
        endcase
    endfunction

    assign mode_ok = mode_valid(rom_loading);
    assign idle_go = mode_ok && !(hold_q && (rom_loading == mode_q));
    assign done_go = mode_ok && (rom_loading != mode_q);
    assign start   = ((state_q == ST_IDLE) && idle_go) || ((state_q == ST_DONE) && done_go);
    assign leave   = (state_q == ST_LOAD) && (rom_loading != mode_q);
    // Bytes arriving on the cycle the mode changes belong to no load
    assign take    = (state_q == ST_LOAD) && !leave && rom_do_valid;
    assign drained = fifo_empty && !req_q;
    assign pop     = req_q && mem.mem_ack;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (idle_go) state_d = ST_LOAD;
            ST_LOAD:  if (leave)   state_d = ST_FLUSH;
            ST_FLUSH: if (drained) state_d = ST_DONE;
            ST_DONE:  state_d = done_go ? ST_LOAD : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = 1'b0;
        load_done = 1'b0;
        case (state_q)
            ST_LOAD, ST_FLUSH: busy = 1'b1;
            ST_DONE:           load_done = 1'b1;
            default:           ;
        endcase
    end

    // Word completion: odd byte closes a pair, or the trailing byte on flush
    always_comb begin
        push           = 1'b0;
        push_word.ds   = 2'b11;
        push_word.data = {rom_do, pair_q};
        if (leave && phase_q) begin
            push           = 1'b1;
            push_word.ds   = 2'b01;
            push_word.data = {8'hFF, pair_q};
        end else if (take && (mode_q != LOAD_CFG) && phase_q) begin
            push = 1'b1;
        end
    end

    assign fifo_din = {ptr_q, push_word};

    // Load bookkeeping: mode latch, byte count, pairing, pointer, overflow, config
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= LOAD_IDLE;
            hold_q  <= 1'b0;
            bytes_q <= '0;
            phase_q <= 1'b0;
            pair_q  <= '0;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            cfg_q   <= '0;
        end else if (start) begin
            mode_q  <= rom_loading;
            hold_q  <= 1'b0;
            bytes_q <= '0;
            phase_q <= 1'b0;
            pair_q  <= '0;
            ptr_q   <= base_of(rom_loading);
            ovf_q   <= 1'b0;
            if (rom_loading == LOAD_CFG) cfg_q <= '0;
        end else begin
            if (take) begin
                if (bytes_q != '1) bytes_q <= bytes_q + 1'b1;
                if (mode_q == LOAD_CFG) begin
                    if (bytes_q < (AW+1)'(4)) cfg_q[{bytes_q[1:0], 3'b000} +: 8] <= rom_do;
                end else begin
                    phase_q <= ~phase_q;
                    if (!phase_q) pair_q <= rom_do;
                end
            end
            if (leave) phase_q <= 1'b0;
            // A full FIFO drops the word but its address slot is still consumed
            if (push) begin
                ptr_q <= ptr_q + AW'(2);
                if (!push_ok) ovf_q <= 1'b1;
            end
            if ((state_q == ST_DONE) && !done_go)                hold_q <= 1'b1;
            if ((state_q == ST_IDLE) && (rom_loading != mode_q)) hold_q <= 1'b0;
        end
    end

    romload_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push),
        .din_i     (fifo_din),
        .push_ok_o (push_ok),
        .pop_i     (pop),
        .dout_o    (fifo_dout),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign head_word = fifo_dout[$bits(word_t)-1:0];

    // Writer: present the FIFO head, hold until ack, then idle one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ds_q    <= '0;
        end else if (!req_q && !fifo_empty) begin
            req_q   <= 1'b1;
            addr_q  <= fifo_dout[FW-1 -: AW];
            wdata_q <= head_word.data;
            ds_q    <= head_word.ds;
        end else if (pop) begin
            req_q <= 1'b0;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_ds    = ds_q;

    assign load_mode  = mode_q;
    assign load_bytes = bytes_q;
    assign overflow   = ovf_q;
    assign cfg_word   = cfg_q;

`ifdef ROMLOAD_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       hdr_q;
    logic [7:0] chk_exp;

    assign chk_exp = 8'h00 - sum_q - 8'h19;

    // GBA header complement check over the mode-1 stream
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
            hdr_q <= 1'b1;
        end else if (start) begin
            sum_q <= '0;
            hdr_q <= 1'b0;
        end else if (take && (mode_q == LOAD_ROM)) begin
            if ((bytes_q >= (AW+1)'(HDR_SUM_FIRST)) && (bytes_q < (AW+1)'(HDR_CHK)))
                sum_q <= sum_q + rom_do;
            if (bytes_q == (AW+1)'(HDR_CHK))
                hdr_q <= (rom_do == chk_exp);
        end
    end

    assign header_ok = hdr_q;
`else
    assign header_ok = 1'b1;
`endif

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_rom_stream_loader.sv
// Scoreboard bench for rom_stream_loader: expected SDRAM writes are queued as
// bytes are streamed and compared when the bench's memory model acks them.
module tb_rom_stream_loader;
    localparam int          AW        = 25;
    localparam logic [24:0] ROM_BASE  = 25'h000_0000;
    localparam logic [24:0] CRAM_BASE = 25'h1F0_0000;
    localparam logic [24:0] BIOS_BASE = 25'h1FC_0000;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [24:0] addr;
        logic [15:0] data;
        logic [1:0]  ds;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  rom_loading;
    logic [7:0]  rom_do;
    logic        rom_do_valid;
    logic        busy, load_done, overflow, header_ok;
    logic [2:0]  load_mode;
    logic [AW:0] load_bytes;
    logic [31:0] cfg_word;

    int   checks = 0;
    int   failures = 0;
    wr_t  sb[$];
    int   ack_lat = 3;
    bit   ack_hold = 0;
    int   req_cycles = 0;

    rom_stream_loader_if #(.AW(AW)) mem_if ();

    rom_stream_loader #(
        .AW(AW), .ROM_BASE(ROM_BASE), .CRAM_BASE(CRAM_BASE), .BIOS_BASE(BIOS_BASE), .DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .rom_loading(rom_loading), .rom_do(rom_do),
        .rom_do_valid(rom_do_valid), .mem(mem_if.master), .busy(busy), .load_done(load_done),
        .load_mode(load_mode), .load_bytes(load_bytes), .overflow(overflow),
        .cfg_word(cfg_word), .header_ok(header_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: ack after ack_lat cycles of mem_req, check against scoreboard
    initial begin
        int  wait_cnt = 0;
        wr_t e;
        mem_if.mem_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (mem_if.mem_req) req_cycles++;
            if (mem_if.mem_ack) begin
                mem_if.mem_ack = 1'b0;
                wait_cnt = 0;
            end else if (mem_if.mem_req && !ack_hold && !reset) begin
                if (wait_cnt >= ack_lat) begin
                    mem_if.mem_ack = 1'b1;
                    wait_cnt = 0;
                    chk("write_expected", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("wr_addr", 64'(mem_if.mem_addr), 64'(e.addr));
                        chk("wr_data", 64'(mem_if.mem_wdata), 64'(e.data));
                        chk("wr_ds", 64'(mem_if.mem_ds), 64'(e.ds));
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] v);
        rom_do = v;
        rom_do_valid = 1'b1;
        @(posedge clk); #1;
        rom_do_valid = 1'b0;
    endtask

    // Bursts of 4 bytes followed by 8 idle cycles
    task automatic stream(input bq_t b);
        for (int i = 0; i < b.size(); i++) begin
            send_byte(b[i]);
            if (i % 4 == 3) idle(8);
        end
    endtask

    task automatic expect_words(input bq_t b, input logic [24:0] base);
        wr_t e;
        for (int i = 0; i + 1 < b.size(); i += 2) begin
            e.addr = base + 25'(i);
            e.data = {b[i+1], b[i]};
            e.ds   = 2'b11;
            sb.push_back(e);
        end
        if (b.size() % 2 == 1) begin
            e.addr = base + 25'(b.size() - 1);
            e.data = {8'hFF, b[b.size()-1]};
            e.ds   = 2'b01;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk); #1;
            if (load_done) seen = 1;
        end
        chk({tag, "_done"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !mem_if.mem_req) ok = 1;
        end
        chk({tag, "_drain"}, 64'(ok), 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"},   64'(mem_if.mem_req), 64'd0);
        chk({tag, "_addr"},  64'(mem_if.mem_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(mem_if.mem_wdata), 64'd0);
        chk({tag, "_ds"},    64'(mem_if.mem_ds), 64'd0);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_done"},  64'(load_done), 64'd0);
        chk({tag, "_mode"},  64'(load_mode), 64'd0);
        chk({tag, "_bytes"}, 64'(load_bytes), 64'd0);
        chk({tag, "_ovf"},   64'(overflow), 64'd0);
        chk({tag, "_cfg"},   64'(cfg_word), 64'd0);
        chk({tag, "_hdr"},   64'(header_ok), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t q;
        int  rc;
        reset = 1'b1; rom_loading = 3'd0; rom_do = 8'h00; rom_do_valid = 1'b0;
        idle(3);
        check_reset_vals("rst");
        reset = 1'b0;
        idle(2);

        // Mode 1: 8 bytes, also checks odd-byte-to-request latency
        q = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        expect_words(q, ROM_BASE);
        rom_loading = 3'd1;
        idle(1);
        chk("m1_busy", 64'(busy), 64'd1);
        send_byte(8'h00);
        send_byte(8'h01);
        chk("lat_n1_req", 64'(mem_if.mem_req), 64'd0);
        idle(1);
        chk("lat_n2_req", 64'(mem_if.mem_req), 64'd1);
        q = {8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        stream(q);
        rom_loading = 3'd0;
        wait_done("m1");
        chk("m1_bytes", 64'(load_bytes), 64'd8);
        chk("m1_sb_empty", 64'(sb.size()), 64'd0);
`ifndef ROMLOAD_CHECKSUM_EN
        chk("m1_hdr", 64'(header_ok), 64'd1);
`endif
        idle(1);
        chk("m1_done_pulse", 64'(load_done), 64'd0);
        chk("m1_idle", 64'(busy), 64'd0);

        // Mode 2: odd length, trailing byte padded
        q = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        expect_words(q, CRAM_BASE);
        rom_loading = 3'd2;
        idle(1);
        stream(q);
        rom_loading = 3'd0;
        wait_done("m2");
        chk("m2_bytes", 64'(load_bytes), 64'd5);
        chk("m2_mode", 64'(load_mode), 64'd2);
        chk("m2_sb_empty", 64'(sb.size()), 64'd0);
        idle(2);

        // Mode 3: config word, no SDRAM traffic
        rc = req_cycles;
        q = {8'h78, 8'h56, 8'h34, 8'h12, 8'h9A};
        rom_loading = 3'd3;
        idle(1);
        stream(q);
        rom_loading = 3'd0;
        wait_done("m3");
        chk("m3_cfg", 64'(cfg_word), 64'h12345678);
        chk("m3_bytes", 64'(load_bytes), 64'd5);
        chk("m3_no_req", 64'(req_cycles - rc), 64'd0);
        idle(2);

        // Overflow: ack held while 32 bytes stream; only 4 words fit the FIFO
        ack_hold = 1;
        q = {};
        for (int i = 0; i < 32; i++) q.push_back(8'(i));
        for (int i = 0; i < 4; i++) begin
            wr_t e;
            e.addr = ROM_BASE + 25'(2*i);
            e.data = {8'(2*i+1), 8'(2*i)};
            e.ds   = 2'b11;
            sb.push_back(e);
        end
        rom_loading = 3'd1;
        idle(1);
        stream(q);
        idle(4);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_bytes", 64'(load_bytes), 64'd32);
        ack_hold = 0;
        wait_drain("ovf_kept");
        begin
            wr_t e;
            e.addr = ROM_BASE + 25'h20;
            e.data = 16'hB1B0;
            e.ds   = 2'b11;
            sb.push_back(e);
        end
        send_byte(8'hB0);
        send_byte(8'hB1);
        wait_drain("ovf_adv");
        chk("ovf_sticky", 64'(overflow), 64'd1);
        rom_loading = 3'd0;
        wait_done("ovf");
        chk("ovf_bytes2", 64'(load_bytes), 64'd34);
        idle(1);
        rom_loading = 3'd2;
        idle(1);
        chk("ovf_clear", 64'(overflow), 64'd0);
        chk("ovf_bytes_clear", 64'(load_bytes), 64'd0);
        rom_loading = 3'd0;
        wait_done("m2e");
        idle(2);

        // Mode 1 straight into mode 4
        q = {8'h11, 8'h22, 8'h33};
        expect_words(q, ROM_BASE);
        rom_loading = 3'd1;
        idle(1);
        stream(q);
        rom_loading = 3'd4;
        wait_done("m14");
        chk("m14_mode_done", 64'(load_mode), 64'd1);
        chk("m14_bytes", 64'(load_bytes), 64'd3);
        idle(1);
        chk("m4_busy", 64'(busy), 64'd1);
        chk("m4_mode", 64'(load_mode), 64'd4);
        q = {8'h44, 8'h55};
        expect_words(q, BIOS_BASE);
        stream(q);
        wait_drain("m4");
        chk("m4_bytes", 64'(load_bytes), 64'd2);

        // Reset with a write outstanding and a byte buffered
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        idle(1);
        chk("pre_rst_req", 64'(mem_if.mem_req), 64'd1);
        reset = 1'b1;
        rom_loading = 3'd0;
        idle(1);
        sb.delete();
        check_reset_vals("midrst");
        idle(1);
        reset = 1'b0;
        idle(2);

`ifdef ROMLOAD_CHECKSUM_EN
        // GBA header checksum: valid then corrupted complement byte
        for (int pass = 0; pass < 2; pass++) begin
            logic [7:0] sum;
            q = {};
            sum = 8'h00;
            for (int i = 0; i < 'hBE; i++) q.push_back(8'(i*7 + 3));
            for (int i = 'hA0; i < 'hBD; i++) sum = sum + q[i];
            q[8'hBD] = 8'h00 - sum - 8'h19 + 8'(pass);
            expect_words(q, ROM_BASE);
            rom_loading = 3'd1;
            idle(1);
            stream(q);
            rom_loading = 3'd0;
            wait_done("hdr");
            chk("hdr_ok", 64'(header_ok), 64'(pass == 0));
            idle(2);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
